bit_demodulator: RTL and testbench

Receive-side counterpart to the modulator signal selector. Takes the 12-bit ADC sample stream carrying an ASK- or BPSK-modulated carrier, correlates it against a local 12-bit carrier reference over a fixed number of samples per bit, and emits one recovered bit per bit period with a single-cycle valid strobe. It sits between the ADC sample interface and the Nios-facing bit/byte capture logic.

---
 rtl/bit_demodulator_if.sv | 39 +++
 rtl/bit_demodulator.sv | 202 ++++++++++++++++++++
 tb/tb_bit_demodulator.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_demodulator_if.sv
// rtl/bit_demodulator_if.sv - sample stream in / recovered bit out bundle for bit_demodulator
//
// Purpose: groups the ADC-side sample stream and the recovered-bit strobe.
// Signals:
//   sample_valid  qualifies sample, ref_wave and bit_start
//   sample        12-bit offset-binary ADC sample (midscale 2048)
//   ref_wave      12-bit offset-binary local carrier, phase-aligned to sample
//   bit_start     marks the first sample of a bit
//   bit_out       last decided bit
//   bit_valid     one-cycle strobe, new bit_out
// Modports:
//   master  sample source / bit consumer
//   slave   demodulator
interface bit_demodulator_if;
  logic        sample_valid;
  logic [11:0] sample;
  logic [11:0] ref_wave;
  logic        bit_start;
  logic        bit_out;
  logic        bit_valid;

  modport master (
    output sample_valid,
    output sample,
    output ref_wave,
    output bit_start,
    input  bit_out,
    input  bit_valid
  );

  modport slave (
    input  sample_valid,
    input  sample,
    input  ref_wave,
    input  bit_start,
    output bit_out,
    output bit_valid
  );
endinterface

// File: rtl/bit_demodulator.sv
// rtl/bit_demodulator.sv - ASK/BPSK correlating bit demodulator
//
// Purpose: centres each ADC sample and the local carrier reference, forms a
// per-sample term (BPSK: s*r, ASK: |s|), integrates SAMPLES_PER_BIT terms and
// emits one decided bit per bit period with a registered one-cycle strobe.
// Framing is free-running once the first bit_start has been seen; a later
// bit_start resynchronises the bit boundary.
//
// Optional feature macro: DEMOD_BIT_COUNT_EN (decided-bit counter).
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   enable         level; low returns the block to IDLE
//   mode           0 = ASK, 1 = BPSK; latched at the first sample of a bit
//   ask_threshold  unsigned ASK decision threshold in accumulator units
//   s_if           sample stream in, bit_out / bit_valid out (slave modport)
//   busy           high while integrating
//   bit_count      decided-bit counter, 0 when the counter is not built
module bit_demodulator #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int ACC_W           = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [ACC_W-1:0] ask_threshold,
  bit_demodulator_if.slave s_if,
  output logic             busy,
  output logic [15:0]      bit_count
);

  localparam int                CNT_W    = (SAMPLES_PER_BIT > 2) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SAMPLES_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_INTEGRATE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic                    bit_out_q, bit_out_d;
  logic                    bit_valid_q, bit_valid_d;

  // Sample datapath
  logic signed [12:0]      s_c;
  logic signed [12:0]      r_c;
  logic signed [25:0]      prod_c;
  logic [12:0]             abs_c;
  logic                    first_c;
  logic                    term_mode_c;
  logic signed [ACC_W-1:0] term_c;
  logic signed [ACC_W-1:0] sum_c;
  logic                    decision_c;

  always_comb begin
    s_c    = $signed({1'b0, s_if.sample})   - 13'sd2048;
    r_c    = $signed({1'b0, s_if.ref_wave}) - 13'sd2048;
    prod_c = s_c * r_c;
    // 13 bits hold |-2048| = 2048 without overflow
    abs_c  = s_c[12] ? -s_c : s_c;

    // The first sample of a bit (fresh frame or resync) uses the live mode
    // input, because that is the sample at which mode gets latched.
    first_c     = s_if.bit_start || (cnt_q == '0);
    term_mode_c = first_c ? mode : mode_q;

    if (term_mode_c) begin
      term_c = {{(ACC_W-26){prod_c[25]}}, prod_c};
    end else begin
      term_c = {{(ACC_W-13){1'b0}}, abs_c};
    end

    sum_c = acc_q + term_c;

    // BPSK: strictly positive sum; ASK: strictly above threshold. The last
    // sample of a bit is never the first, so mode_q is the right mode here.
    if (mode_q) begin
      decision_c = !sum_c[ACC_W-1] && (sum_c != '0);
    end else begin
      decision_c = $unsigned(sum_c) > ask_threshold;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (enable) begin
          state_d = ST_WAIT_START;
        end
      end

      ST_WAIT_START: begin
        if (s_if.sample_valid && s_if.bit_start) begin
          acc_d   = term_c;
          cnt_d   = CNT_W'(1);
          mode_d  = mode;
          state_d = ST_INTEGRATE;
        end
      end

      ST_INTEGRATE: begin
        if (s_if.sample_valid) begin
          if (first_c) begin
            // New frame or resync: any partial sum is dropped. Resync wins
            // over a coinciding last sample, so no decision is made then.
            acc_d  = term_c;
            cnt_d  = CNT_W'(1);
            mode_d = mode;
          end else if (cnt_q == LAST_CNT) begin
            bit_out_d   = decision_c;
            bit_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            acc_d = sum_c;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Dropping enable discards the partial bit from any state; bit_out holds.
    if (!enable) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      mode_d      = mode_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

`ifdef DEMOD_BIT_COUNT_EN
  // Counts alongside the bit_valid pulse; wraps naturally at 16 bits and is
  // deliberately untouched by enable.
  logic [15:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    if (bit_valid_d) begin
      bit_count_d = bit_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_count_q <= 16'd0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`else
  assign bit_count = 16'd0;
`endif

  assign s_if.bit_out   = bit_out_q;
  assign s_if.bit_valid = bit_valid_q;
  assign busy           = (state_q == ST_INTEGRATE);

endmodule

// File: tb/tb_bit_demodulator.sv
// tb/tb_bit_demodulator.sv - self-checking bench for bit_demodulator
module tb_bit_demodulator;
  localparam int SPB   = 16;
  localparam int ACC_W = 40;
`ifdef DEMOD_BIT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             mode;
  logic [ACC_W-1:0] ask_threshold;
  logic             busy;
  logic [15:0]      bit_count;

  bit_demodulator_if sif ();

  bit_demodulator #(
    .SAMPLES_PER_BIT(SPB),
    .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .ask_threshold(ask_threshold),
    .s_if(sif),
    .busy(busy),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          exp_count = 0;
  logic        exp_bit   = 1'b0;
  logic [11:0] smp [SPB];
  logic [11:0] rw  [SPB];

  // Reference: correlation sum over one bit straight from the arithmetic rules
  function automatic longint model_sum(input logic m);
    longint acc, s, r;
    acc = 0;
    for (int i = 0; i < SPB; i++) begin
      s = longint'(smp[i]) - 2048;
      r = longint'(rw[i]) - 2048;
      if (m) acc += s * r;
      else   acc += (s < 0) ? -s : s;
    end
    return acc;
  endfunction

  function automatic logic model_bit(input logic m, input longint thr);
    longint t;
    t = model_sum(m);
    return m ? (t > 0) : (t > thr);
  endfunction

  task automatic fill(input logic [11:0] s, input logic [11:0] r);
    for (int i = 0; i < SPB; i++) begin
      smp[i] = s;
      rw[i]  = r;
    end
  endtask

  // One clock: drive inputs just after an edge, observe just after the next
  task automatic step(input logic v, input logic [11:0] s, input logic [11:0] r, input logic st);
    sif.sample_valid = v;
    sif.sample       = s;
    sif.ref_wave     = r;
    sif.bit_start    = st;
    @(posedge clk);
    #1;
    sif.sample_valid = 1'b0;
    sif.bit_start    = 1'b0;
  endtask

  // Sends smp/rw as one bit with gmin..gmax idle cycles before each sample.
  // early counts bit_valid seen before the last sample, last_v is bit_valid after it.
  task automatic send_bit(input logic m, input logic first_start, input int gmin, input int gmax,
                          output int early, output logic last_v);
    int g;
    early  = 0;
    last_v = 1'b0;
    for (int i = 0; i < SPB; i++) begin
      g = int'($urandom_range(gmax, gmin));
      repeat (g) begin
        step(1'b0, 12'($urandom), 12'($urandom), 1'($urandom));
        early += int'(sif.bit_valid);
      end
      mode = (i == 0) ? m : 1'($urandom);
      step(1'b1, smp[i], rw[i], (i == 0) ? first_start : 1'b0);
      if (i < SPB - 1) early += int'(sif.bit_valid);
      else             last_v = sif.bit_valid;
    end
  endtask

  // Random bit contents; ASK threshold placed at sum-1, sum or sum+1
  task automatic prep_bit(output logic m, output logic eb);
    longint t, thr;
    m = 1'($urandom);
    for (int i = 0; i < SPB; i++) begin
      smp[i] = 12'($urandom);
      rw[i]  = 12'($urandom);
    end
    t   = model_sum(m);
    thr = t + longint'($urandom_range(2, 0)) - 1;
    if (thr < 0) thr = 0;
    ask_threshold = ACC_W'(thr);
    eb = model_bit(m, thr);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; mode = 1'b0; ask_threshold = '0;
    sif.sample_valid = 1'b0; sif.sample = '0; sif.ref_wave = '0; sif.bit_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (sif.bit_out !== 1'b0)   begin n_fail++; $display("FAIL reset_bit_out: got %b want 0", sif.bit_out); end
    n_checks++; if (sif.bit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bit_valid: got %b want 0", sif.bit_valid); end
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (bit_count !== 16'd0)    begin n_fail++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
    reset = 1'b0;
    exp_count = 0;
    exp_bit   = 1'b0;
  endtask

  task automatic test_bpsk_basic();
    int early; logic lv;
    enable = 1'b1;
    step(1'b0, 12'd0, 12'd0, 1'b0);
    fill(12'd3048, 12'd3048);
    send_bit(1'b1, 1'b1, 0, 0, early, lv);
    exp_count++; exp_bit = 1'b1;
    n_checks++; if (early !== 0)           begin n_fail++; $display("FAIL bpsk_early_valid: got %0d want 0", early); end
    n_checks++; if (lv !== 1'b1)           begin n_fail++; $display("FAIL bpsk_valid: got %b want 1", lv); end
    n_checks++; if (sif.bit_out !== 1'b1)  begin n_fail++; $display("FAIL bpsk_bit_out: got %b want 1", sif.bit_out); end
    n_checks++; if (busy !== 1'b1)         begin n_fail++; $display("FAIL bpsk_busy: got %b want 1", busy); end
    step(1'b0, 12'd0, 12'd0, 1'b0);
    n_checks++; if (sif.bit_valid !== 1'b0) begin n_fail++; $display("FAIL bpsk_valid_one_cycle: got %b want 0", sif.bit_valid); end
    n_checks++; if (sif.bit_out !== 1'b1)   begin n_fail++; $display("FAIL bpsk_bit_out_hold: got %b want 1", sif.bit_out); end
    n_checks++; if (busy !== 1'b1)          begin n_fail++; $display("FAIL bpsk_busy_hold: got %b want 1", busy); end
  endtask

  task automatic test_free_run();
    int early; logic lv;
    fill(12'd1048, 12'd3048);
    send_bit(1'b1, 1'b0, 0, 0, early, lv);
    exp_count++; exp_bit = 1'b0;
    n_checks++; if (early !== 0 || lv !== 1'b1) begin n_fail++; $display("FAIL free_run_neg_valid: early %0d last %b want 0/1", early, lv); end
    n_checks++; if (sif.bit_out !== 1'b0)       begin n_fail++; $display("FAIL free_run_neg_bit: got %b want 0", sif.bit_out); end
    fill(12'd3048, 12'd3048);
    send_bit(1'b1, 1'b0, 0, 0, early, lv);
    exp_count++; exp_bit = 1'b1;
    n_checks++; if (early !== 0 || lv !== 1'b1) begin n_fail++; $display("FAIL free_run_pos_valid: early %0d last %b want 0/1", early, lv); end
    n_checks++; if (sif.bit_out !== 1'b1)       begin n_fail++; $display("FAIL free_run_pos_bit: got %b want 1", sif.bit_out); end
  endtask

  task automatic test_ask_threshold();
    int early; logic lv;
    ask_threshold = ACC_W'(8000);
    fill(12'd2548, 12'($urandom));
    send_bit(1'b0, 1'b0, 0, 0, early, lv);
    exp_count++; exp_bit = 1'b0;
    n_checks++; if (early !== 0 || lv !== 1'b1) begin n_fail++; $display("FAIL ask_equal_valid: early %0d last %b want 0/1", early, lv); end
    n_checks++; if (sif.bit_out !== 1'b0)       begin n_fail++; $display("FAIL ask_equal_bit: got %b want 0", sif.bit_out); end
    fill(12'd2549, 12'($urandom));
    send_bit(1'b0, 1'b0, 0, 0, early, lv);
    exp_count++; exp_bit = 1'b1;
    n_checks++; if (early !== 0 || lv !== 1'b1) begin n_fail++; $display("FAIL ask_above_valid: early %0d last %b want 0/1", early, lv); end
    n_checks++; if (sif.bit_out !== 1'b1)       begin n_fail++; $display("FAIL ask_above_bit: got %b want 1", sif.bit_out); end
  endtask

  task automatic test_gapped();
    int early; logic lv, m, eb;
    prep_bit(m, eb);
    send_bit(m, 1'b1, 2, 2, early, lv);
    exp_count++; exp_bit = eb;
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL gapped_early_valid: got %0d want 0", early); end
    n_checks++; if (lv !== 1'b1) begin n_fail++; $display("FAIL gapped_valid: got %b want 1", lv); end
    n_checks++; if (sif.bit_out !== eb) begin n_fail++; $display("FAIL gapped_bit: got %b want %b", sif.bit_out, eb); end
  endtask

  task automatic test_resync();
    int early, pre; logic lv;
    // Strongly negative partial bit, then resync at its 5th sample
    pre = 0;
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 12'd1048, 12'd3048, i == 0);
      pre += int'(sif.bit_valid);
    end
    fill(12'd2049, 12'd3048);
    send_bit(1'b1, 1'b1, 0, 0, early, lv);
    exp_count++; exp_bit = 1'b1;
    n_checks++; if (early + pre !== 0) begin n_fail++; $display("FAIL resync5_early_valid: got %0d want 0", early + pre); end
    n_checks++; if (lv !== 1'b1)       begin n_fail++; $display("FAIL resync5_valid: got %b want 1", lv); end
    n_checks++; if (sif.bit_out !== 1'b1) begin n_fail++; $display("FAIL resync5_bit: got %b want 1", sif.bit_out); end
    // bit_start landing on the 16th sample of a bit suppresses that decision
    pre = 0;
    mode = 1'b1;
    for (int i = 0; i < SPB - 1; i++) begin
      step(1'b1, 12'd3048, 12'd3048, i == 0);
      pre += int'(sif.bit_valid);
    end
    fill(12'd1048, 12'd3048);
    send_bit(1'b1, 1'b1, 0, 0, early, lv);
    exp_count++; exp_bit = 1'b0;
    n_checks++; if (early + pre !== 0) begin n_fail++; $display("FAIL resync16_early_valid: got %0d want 0", early + pre); end
    n_checks++; if (lv !== 1'b1)       begin n_fail++; $display("FAIL resync16_valid: got %b want 1", lv); end
    n_checks++; if (sif.bit_out !== 1'b0) begin n_fail++; $display("FAIL resync16_bit: got %b want 0", sif.bit_out); end
  endtask

  task automatic test_random_bits(input int nbits, input int gmax, input string tag);
    int early; logic lv, m, eb;
    for (int b = 0; b < nbits; b++) begin
      prep_bit(m, eb);
      send_bit(m, 1'($urandom), 0, gmax, early, lv);
      exp_count++; exp_bit = eb;
      n_checks++; if (early !== 0) begin n_fail++; $display("FAIL %s_bit%0d_early_valid: got %0d want 0", tag, b, early); end
      n_checks++; if (lv !== 1'b1) begin n_fail++; $display("FAIL %s_bit%0d_valid: got %b want 1", tag, b, lv); end
      n_checks++; if (sif.bit_out !== eb) begin n_fail++; $display("FAIL %s_bit%0d_value: got %b want %b (mode %b)", tag, b, sif.bit_out, eb, m); end
    end
  endtask

  task automatic test_enable_drop();
    int cnt, early; logic lv, m, eb;
    cnt = 0;
    prep_bit(m, eb);
    mode = m;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, smp[i], rw[i], i == 0);
      cnt += int'(sif.bit_valid);
    end
    enable = 1'b0;
    step(1'b0, 12'd0, 12'd0, 1'b0);
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL en_drop_busy: got %b want 0", busy); end
    n_checks++; if (sif.bit_out !== exp_bit) begin n_fail++; $display("FAIL en_drop_bit_hold: got %b want %b", sif.bit_out, exp_bit); end
    repeat (8) begin
      step(1'b1, 12'($urandom), 12'($urandom), 1'($urandom));
      cnt += int'(sif.bit_valid);
    end
    n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL en_drop_no_valid: got %0d want 0", cnt); end
    enable = 1'b1;
    step(1'b0, 12'd0, 12'd0, 1'b0);
    repeat (5) step(1'b1, 12'($urandom), 12'($urandom), 1'b0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_start_ignore_busy: got %b want 0", busy); end
    send_bit(m, 1'b1, 0, 1, early, lv);
    exp_count++; exp_bit = eb;
    n_checks++; if (early !== 0 || lv !== 1'b1) begin n_fail++; $display("FAIL reenable_valid: early %0d last %b want 0/1", early, lv); end
    n_checks++; if (sif.bit_out !== eb)        begin n_fail++; $display("FAIL reenable_bit: got %b want %b", sif.bit_out, eb); end
  endtask

  task automatic test_bit_count_reset();
    int early, cnt; logic lv;
    fill(12'd3048, 12'd3048);
    send_bit(1'b1, 1'b1, 0, 0, early, lv);
    exp_count++; exp_bit = 1'b1;
    n_checks++; if (sif.bit_out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_bit: got %b want 1", sif.bit_out); end
    n_checks++; if (bit_count !== (CNT_EN ? 16'(exp_count) : 16'd0)) begin
      n_fail++; $display("FAIL bit_count: got %0d want %0d", bit_count, CNT_EN ? 16'(exp_count) : 16'd0);
    end
    mode = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 12'd3048, 12'd3048, i == 0);
    reset = 1'b1;
    #1;
    n_checks++; if (sif.bit_out !== 1'b0)   begin n_fail++; $display("FAIL midbit_reset_bit_out: got %b want 0", sif.bit_out); end
    n_checks++; if (sif.bit_valid !== 1'b0) begin n_fail++; $display("FAIL midbit_reset_bit_valid: got %b want 0", sif.bit_valid); end
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL midbit_reset_busy: got %b want 0", busy); end
    n_checks++; if (bit_count !== 16'd0)    begin n_fail++; $display("FAIL midbit_reset_bit_count: got %0d want 0", bit_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_count = 0; exp_bit = 1'b0;
    // Reset arriving together with the last sample leaves no pending strobe
    step(1'b0, 12'd0, 12'd0, 1'b0);
    for (int i = 0; i < SPB - 1; i++) step(1'b1, 12'd3048, 12'd3048, i == 0);
    sif.sample_valid = 1'b1; sif.sample = 12'd3048; sif.ref_wave = 12'd3048; sif.bit_start = 1'b0;
    #5 reset = 1'b1;
    @(posedge clk); #1;
    sif.sample_valid = 1'b0;
    reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      step(1'b0, 12'd0, 12'd0, 1'b0);
      cnt += int'(sif.bit_valid);
    end
    n_checks++; if (cnt !== 0)           begin n_fail++; $display("FAIL last_sample_reset_valid: got %0d want 0", cnt); end
    n_checks++; if (sif.bit_out !== 1'b0) begin n_fail++; $display("FAIL last_sample_reset_bit: got %b want 0", sif.bit_out); end
    n_checks++; if (bit_count !== 16'd0) begin n_fail++; $display("FAIL last_sample_reset_count: got %0d want 0", bit_count); end
  endtask

  initial begin
    test_reset();
    test_bpsk_basic();
    test_free_run();
    test_ask_threshold();
    test_gapped();
    test_resync();
    test_random_bits(4, 0, "back_to_back");
    test_random_bits(24, 3, "random");
    test_enable_drop();
    test_bit_count_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
